// File: rtl/itch_encoder.sv
// Serialises one add/delete/execute order into the 32-bit word stream the parser consumes.
// Define ITCH_ENC_CHECKSUM_EN to append a tenth word holding the XOR of words 0..8.
module itch_encoder #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [1:0]           i_order_type,
  input  logic                 i_trade_type,
  input  logic [1:0]           i_stock_symbol,
  input  logic [31:0]          i_order_id,
  input  logic [31:0]          i_price,
  input  logic [31:0]          i_quantity,
  input  logic [63:0]          i_curr_time,
  input  logic [15:0]          i_locate_code,
  output logic [REG_WIDTH-1:0] o_word,
  output logic                 o_word_valid,
  input  logic                 i_word_ready,
  output logic [3:0]           o_word_idx,
  output logic                 o_word_last,
  output logic                 o_err
);

`ifdef ITCH_ENC_CHECKSUM_EN
  localparam int MSG_WORDS = 10;
`else
  localparam int MSG_WORDS = 9;
`endif
  localparam logic [3:0] LAST_IDX = 4'(MSG_WORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state;
  logic [15:0]          trk_cnt;
  logic [REG_WIDTH-1:0] buf_q [MSG_WORDS];
  logic [REG_WIDTH-1:0] msg_w [9];
  logic [63:0]          stock_id;
  logic [63:0]          oid;
  logic [7:0]           type_char;
  logic [3:0]           nxt_idx;
  logic                 accept;
  logic                 unused_time_lo;

  function automatic logic [63:0] stock_ascii(input logic [1:0] sym);
    case (sym)
      2'd0:    return 64'h4141504C20202020;
      2'd1:    return 64'h414D5A4E20202020;
      2'd2:    return 64'h474F4F474C202020;
      default: return 64'h4D53465420202020;
    endcase
  endfunction

  assign unused_time_lo = ^i_curr_time[31:0];
  assign o_ready = (state == IDLE) && !i_reset;
  assign accept  = (state == IDLE) && i_valid && (i_order_type != 2'd3);
  assign nxt_idx = o_word_idx + 4'd1;

  always_comb begin
    stock_id = stock_ascii(i_stock_symbol);
    oid      = {32'h0, i_order_id};
    case (i_order_type)
      2'd0:    type_char = 8'h41;
      2'd1:    type_char = 8'h44;
      default: type_char = 8'h45;
    endcase
    msg_w[0] = {trk_cnt[7:0], i_locate_code, type_char};
    msg_w[1] = {i_curr_time[55:32], trk_cnt[15:8]};
    msg_w[2] = {oid[7:0], 16'h0, i_curr_time[63:56]};
    msg_w[3] = oid[39:8];
    msg_w[4] = '0;
    msg_w[5] = '0;
    msg_w[6] = '0;
    msg_w[7] = '0;
    msg_w[8] = '0;
    case (i_order_type)
      2'd0: begin
        msg_w[4] = {7'h0, i_trade_type, 24'h0};
        msg_w[5] = i_quantity;
        msg_w[6] = stock_id[31:0];
        msg_w[7] = stock_id[63:32];
        msg_w[8] = i_price;
      end
      2'd1: begin
        msg_w[4] = {stock_id[7:0], 24'h0};
        msg_w[5] = stock_id[39:8];
        msg_w[6] = {8'h0, stock_id[63:40]};
      end
      2'd2: begin
        msg_w[4] = {i_quantity[7:0], 24'h0};
        msg_w[5] = {stock_id[7:0], i_quantity[31:8]};
        msg_w[6] = stock_id[39:8];
        msg_w[7] = {8'h0, stock_id[63:40]};
      end
      default: ;
    endcase
  end

`ifdef ITCH_ENC_CHECKSUM_EN
  logic [REG_WIDTH-1:0] csum;
  always_comb begin
    csum = '0;
    for (int i = 0; i < 9; i++) csum = csum ^ msg_w[i];
  end
`endif

  // Message buffer is pure data: loaded on accept, never reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int i = 0; i < 9; i++) buf_q[i] <= msg_w[i];
`ifdef ITCH_ENC_CHECKSUM_EN
      buf_q[9] <= csum;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      o_word_valid <= 1'b0;
      o_word       <= '0;
      o_word_idx   <= '0;
      o_word_last  <= 1'b0;
      o_err        <= 1'b0;
      trk_cnt      <= '0;
    end else begin
      o_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid && (i_order_type == 2'd3)) begin
            o_err <= 1'b1;
          end else if (accept) begin
            state        <= SEND;
            o_word       <= msg_w[0];
            o_word_valid <= 1'b1;
            o_word_idx   <= '0;
            o_word_last  <= 1'b0;
            trk_cnt      <= trk_cnt + 16'd1;
          end
        end
        SEND: begin
          if (i_word_ready) begin
            if (o_word_idx == LAST_IDX) begin
              state        <= IDLE;
              o_word_valid <= 1'b0;
              o_word       <= '0;
              o_word_idx   <= '0;
              o_word_last  <= 1'b0;
            end else begin
              o_word_idx  <= nxt_idx;
              o_word      <= buf_q[nxt_idx];
              o_word_last <= (nxt_idx == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_itch_encoder.sv
// Directed self-checking bench for itch_encoder: word layouts, stalls, illegal orders, reset abort.
module tb_itch_encoder;
`ifdef ITCH_ENC_CHECKSUM_EN
  localparam int MSG_WORDS = 10;
`else
  localparam int MSG_WORDS = 9;
`endif

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [1:0]  i_order_type = '0;
  logic        i_trade_type = 1'b0;
  logic [1:0]  i_stock_symbol = '0;
  logic [31:0] i_order_id = '0;
  logic [31:0] i_price = '0;
  logic [31:0] i_quantity = '0;
  logic [63:0] i_curr_time = '0;
  logic [15:0] i_locate_code = '0;
  logic [31:0] o_word;
  logic        o_word_valid;
  logic        i_word_ready = 1'b0;
  logic [3:0]  o_word_idx;
  logic        o_word_last;
  logic        o_err;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] e [10];

  always #5 clk = ~clk;

  itch_encoder dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_order_type(i_order_type), .i_trade_type(i_trade_type),
    .i_stock_symbol(i_stock_symbol), .i_order_id(i_order_id), .i_price(i_price),
    .i_quantity(i_quantity), .i_curr_time(i_curr_time), .i_locate_code(i_locate_code),
    .o_word(o_word), .o_word_valid(o_word_valid), .i_word_ready(i_word_ready),
    .o_word_idx(o_word_idx), .o_word_last(o_word_last), .o_err(o_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_order(input logic [1:0] ty, input logic tr, input logic [1:0] sym,
                            input logic [31:0] id, input logic [31:0] pr, input logic [31:0] qty,
                            input logic [63:0] t, input logic [15:0] loc);
    i_order_type = ty; i_trade_type = tr; i_stock_symbol = sym; i_order_id = id;
    i_price = pr; i_quantity = qty; i_curr_time = t; i_locate_code = loc;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic fill_csum();
    e[9] = '0;
    for (int i = 0; i < 9; i++) e[9] = e[9] ^ e[i];
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    tick();
    tick();
    n_chk++;
    if (o_word_valid !== 1'b0 || o_word !== 32'h0 || o_word_idx !== 4'h0 ||
        o_word_last !== 1'b0 || o_err !== 1'b0 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b word=%h idx=%0d last=%b err=%b ready=%b expected all 0",
               o_word_valid, o_word, o_word_idx, o_word_last, o_err, o_ready);
    end
    i_reset = 1'b0;
    tick();
    n_chk++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: ready=%b expected 1", o_ready);
    end
  endtask

  task automatic test_add();
    e[0] = 32'h00000741; e[1] = 32'hBBCCDD00; e[2] = 32'h780000AA; e[3] = 32'h00123456;
    e[4] = 32'h01000000; e[5] = 32'd100;      e[6] = 32'h20202020; e[7] = 32'h4141504C;
    e[8] = 32'd150;
    fill_csum();
    i_word_ready = 1'b1;
    send_order(2'd0, 1'b1, 2'd0, 32'h12345678, 32'd150, 32'd100, 64'hAABBCCDD_00000000, 16'h0007);
    for (int k = 0; k < MSG_WORDS; k++) begin
      n_chk++;
      if (o_word_valid !== 1'b1 || o_word_idx !== k[3:0] || o_word !== e[k] ||
          o_word_last !== (k == MSG_WORDS - 1)) begin
        n_fail++;
        $display("FAIL add_w%0d: valid=%b idx=%0d word=%h last=%b expected valid=1 idx=%0d word=%h last=%b",
                 k, o_word_valid, o_word_idx, o_word, o_word_last, k, e[k], k == MSG_WORDS - 1);
      end
      tick();
    end
    n_chk++;
    if (o_word_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL add_end: valid=%b ready=%b expected valid=0 ready=1", o_word_valid, o_ready);
    end
  endtask

  task automatic test_execute();
    e[0] = 32'h01010245; e[1] = 32'h22334400; e[2] = 32'hCD000011; e[3] = 32'h000000AB;
    e[4] = 32'h0B000000; e[5] = 32'h2000000A; e[6] = 32'h54202020; e[7] = 32'h004D5346;
    e[8] = 32'h0;
    fill_csum();
    i_word_ready = 1'b1;
    send_order(2'd2, 1'b0, 2'd3, 32'h0000ABCD, 32'hDEADBEEF, 32'h00000A0B,
               64'h11223344_55667788, 16'h0102);
    for (int k = 0; k < MSG_WORDS; k++) begin
      n_chk++;
      if (o_word_valid !== 1'b1 || o_word_idx !== k[3:0] || o_word !== e[k] ||
          o_word_last !== (k == MSG_WORDS - 1)) begin
        n_fail++;
        $display("FAIL exec_w%0d: valid=%b idx=%0d word=%h last=%b expected idx=%0d word=%h",
                 k, o_word_valid, o_word_idx, o_word, o_word_last, k, e[k]);
      end
      tick();
    end
  endtask

  task automatic test_cancel_stall();
    int cur;
    int c;
    logic rdy;
    e[0] = 32'h02BEEF44; e[1] = 32'hEEDDCC00; e[2] = 32'h210000FF; e[3] = 32'h00876543;
    e[4] = 32'h20000000; e[5] = 32'h474C2020; e[6] = 32'h00474F4F; e[7] = 32'h0;
    e[8] = 32'h0;
    fill_csum();
    i_word_ready = 1'b0;
    send_order(2'd1, 1'b1, 2'd2, 32'h87654321, 32'd7, 32'd9, 64'hFFEEDDCC_01020304, 16'hBEEF);
    cur = 0;
    c = 0;
    while (cur < MSG_WORDS && c < 60) begin
      rdy = ((c % 4) == 0) || ((c % 4) == 3);
      i_word_ready = rdy;
      n_chk++;
      if (o_word_valid !== 1'b1 || o_word_idx !== cur[3:0] || o_word !== e[cur] ||
          o_word_last !== (cur == MSG_WORDS - 1)) begin
        n_fail++;
        $display("FAIL cancel_c%0d: valid=%b idx=%0d word=%h last=%b expected idx=%0d word=%h",
                 c, o_word_valid, o_word_idx, o_word, o_word_last, cur, e[cur]);
      end
      tick();
      if (rdy) cur++;
      c++;
    end
    i_word_ready = 1'b1;
    n_chk++;
    if (cur != MSG_WORDS || o_word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_end: words=%0d valid=%b expected words=%0d valid=0",
               cur, o_word_valid, MSG_WORDS);
    end
  endtask

  task automatic test_illegal();
    int nwords;
    send_order(2'd3, 1'b0, 2'd1, 32'h1, 32'h2, 32'h3, 64'h0, 16'h0);
    n_chk++;
    if (o_err !== 1'b1 || o_word_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_pulse: err=%b valid=%b ready=%b expected err=1 valid=0 ready=1",
               o_err, o_word_valid, o_ready);
    end
    tick();
    n_chk++;
    if (o_err !== 1'b0 || o_word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_after: err=%b valid=%b expected 0 0", o_err, o_word_valid);
    end
    i_word_ready = 1'b1;
    send_order(2'd0, 1'b1, 2'd0, 32'h12345678, 32'd150, 32'd100, 64'hAABBCCDD_00000000, 16'h0007);
    n_chk++;
    if (o_word !== 32'h03000741 || o_word_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_trk: word=%h valid=%b expected 03000741 valid=1", o_word, o_word_valid);
    end
    nwords = 0;
    for (int k = 0; k < 20 && o_word_valid === 1'b1; k++) begin
      nwords++;
      tick();
    end
    n_chk++;
    if (nwords != MSG_WORDS) begin
      n_fail++;
      $display("FAIL illegal_len: words=%0d expected %0d", nwords, MSG_WORDS);
    end
  endtask

  task automatic test_reset_mid();
    i_word_ready = 1'b1;
    send_order(2'd2, 1'b0, 2'd3, 32'h0000ABCD, 32'h0, 32'h00000A0B, 64'h11223344_55667788, 16'h0102);
    repeat (4) tick();
    n_chk++;
    if (o_word_idx !== 4'd4 || o_word_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_idx: idx=%0d valid=%b expected 4 1", o_word_idx, o_word_valid);
    end
    i_reset = 1'b1;
    tick();
    n_chk++;
    if (o_word_valid !== 1'b0 || o_word_idx !== 4'd0 || o_word !== 32'h0 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state: valid=%b idx=%0d word=%h ready=%b expected 0 0 0 0",
               o_word_valid, o_word_idx, o_word, o_ready);
    end
    i_reset = 1'b0;
    tick();
    n_chk++;
    if (o_word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: valid=%b expected 0", o_word_valid);
    end
    send_order(2'd2, 1'b0, 2'd3, 32'h0000ABCD, 32'h0, 32'h00000A0B, 64'h11223344_55667788, 16'h0102);
    n_chk++;
    if (o_word !== 32'h00010245) begin
      n_fail++;
      $display("FAIL rstmid_trk_lo: word=%h expected 00010245", o_word);
    end
    tick();
    n_chk++;
    if (o_word !== 32'h22334400 || o_word_idx !== 4'd1) begin
      n_fail++;
      $display("FAIL rstmid_trk_hi: word=%h idx=%0d expected 22334400 1", o_word, o_word_idx);
    end
    repeat (MSG_WORDS) tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_execute();
    test_cancel_stall();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/itch_encoder.md
Name: itch_encoder

Overview:
- Transmit-side counterpart of the order-message parser: takes one decoded order (add / delete / execute) and serialises it as nine 32-bit words in the same 288-bit register layout the parser consumes, word 0 first.
- Sits between the strategy/order-generation logic and the outbound message path; also used as the stimulus generator for parser loopback benches.
- Owns the 16-bit internal tracking-number counter stamped into every emitted message.

Parameters:
- REG_WIDTH, 32, width of each output word. Only 32 is supported.
- MSG_WORDS, 9, words per message, or 10 with ITCH_ENC_CHECKSUM_EN. Derived; not overridable.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  order fields valid
- o_ready  out  1  encoder can accept an order
- i_order_type  in  2  0=ADD, 1=CANCEL(delete), 2=EXECUTE, 3=illegal
- i_trade_type  in  1  0=BUY, 1=SELL (ADD only)
- i_stock_symbol  in  2  0=AAPL, 1=AMZN, 2=GOOGL, 3=MSFT
- i_order_id  in  32  order ID; zero-extended to 64 bits
- i_price  in  32  price (ADD only)
- i_quantity  in  32  shares (ADD, EXECUTE)
- i_curr_time  in  64  time; bits [63:32] are encoded
- i_locate_code  in  16  locate code
- o_word  out  32  message word
- o_word_valid  out  1  o_word valid
- i_word_ready  in  1  downstream accepts o_word
- o_word_idx  out  4  index of current word (0..8, or 0..9)
- o_word_last  out  1  current word is the final word
- o_err  out  1  one-cycle pulse: illegal order type dropped

Behaviour:
- Reset (i_reset=1 at posedge): FSM to IDLE; o_word_valid=0, o_word=0, o_word_idx=0, o_word_last=0, o_err=0, tracking counter=0. Reset mid-message aborts the message with no further words emitted. o_ready is low during the reset cycle.
- FSM states: IDLE, SEND.
- IDLE:
  - o_ready=1.
  - On i_valid with order type 0..2: latch all inputs into a 9-word buffer, capture trk=counter, increment counter (0xFFFF wraps to 0x0000), go to SEND.
  - On i_valid with order type 3: o_err=1 next cycle, nothing emitted, counter unchanged, stay in IDLE.
- SEND:
  - o_ready=0.
  - o_word_valid=1; o_word=buffer[o_word_idx].
  - A word transfers on o_word_valid & i_word_ready; o_word_idx then increments.
  - While i_word_ready=0, o_word and o_word_idx hold stable.
  - o_word_last=1 only when o_word_idx=MSG_WORDS-1.
  - On the last transfer, return to IDLE with o_word_valid=0 next cycle.
  - No back-to-back overlap: the minimum gap between messages is 1 IDLE cycle.
- Latency: order accepted at edge N; word 0 valid after edge N (cycle N+1). 9 cycles minimum with i_word_ready held high.
- Stock ID (64-bit ASCII):
  - AAPL=0x4141504C20202020
  - AMZN=0x414D5A4E20202020
  - GOOGL=0x474F4F474C202020
  - MSFT=0x4D53465420202020
- Definitions: S=stock ID, T=i_curr_time, O={32'h0, i_order_id}, Q=i_quantity.
- Common words (all types):
  - w0={trk[7:0], locate[15:0], type char}; type char: 0x41 'A', 0x44 'D', 0x45 'E'.
  - w1={T[55:32], trk[15:8]}.
  - w2={O[7:0], 16'h0, T[63:56]}.
  - w3=O[39:8].
- ADD:
  - w4={7'h0, trade_type, 24'h0}
  - w5=Q
  - w6=S[31:0]
  - w7=S[63:32]
  - w8=i_price
- CANCEL:
  - w4={S[7:0], 24'h0}
  - w5=S[39:8]
  - w6={8'h0, S[63:40]}
  - w7=0
  - w8=0
- EXECUTE:
  - w4={Q[7:0], 24'h0}
  - w5={S[7:0], Q[31:8]}
  - w6=S[39:8]
  - w7={8'h0, S[63:40]}
  - w8=0
- Round trip: feeding w0..w8 to the parser must reproduce the original type, symbol, order_id, price/qty, trade type, locate, tracking and time[63:32].

Optional Feature:
- ITCH_ENC_CHECKSUM_EN defined: a 10th word w9 = XOR of w0..w8 is appended; o_word_last is asserted on idx 9; MSG_WORDS=10.
- Undefined: 9 words; o_word_last on idx 8; no checksum logic.

Test Plan:
- ADD, AAPL, id=0x12345678, price=150, qty=100, SELL, locate=0x0007, T=0xAABBCCDD_00000000, ready=1 -> w0=0x00000741, w1=0xBBCCDD00, w2=0x780000AA, w3=0x00123456, w4=0x01000000, w5=100, w6=0x20202020, w7=0x4141504C, w8=150; last on idx 8; o_ready high again the following cycle.
- EXECUTE, MSFT, qty=0x00000A0B, second message -> trk=1, so w0[31:24]=0x01; w4=0x0B000000, w5=0x2000000A, w6=0x54202020, w7=0x004D5346, w8=0.
- CANCEL, GOOGL, i_word_ready toggled 1,0,0,1 -> o_word/o_word_idx hold while stalled; w4=0x20000000, w5=0x474C2020, w6=0x00474F4F.
- i_order_type=3 -> no words emitted, o_err one-cycle pulse, next valid message carries the unchanged trk.
- 65537 accepted messages -> trk wraps 0xFFFF->0x0000; i_reset asserted at word idx 4 -> o_word_valid=0 next cycle, o_word_idx=0, trk=0.
- With ITCH_ENC_CHECKSUM_EN: the ADD case from the first scenario -> w9 = XOR(w0..w8), o_word_last on idx 9 only.
